// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite fetch path: tile geometry, tile codes,
// coin animation frame selects and the colour-key rule for coin ROM data.
package sprite_pkg;

    localparam int TILE_W   = 24;
    localparam int COIN_W   = 16;
    localparam int COIN_OFF = (TILE_W - COIN_W) / 2;

    localparam logic [11:0] TRANSP_RGB     = 12'hF0F;
    localparam logic [11:0] BG_RGB_DEFAULT = 12'h5AF;

    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        TC_EMPTY    = 2'd0,
        TC_GROUND   = 2'd1,
        TC_PLATFORM = 2'd2,
        TC_COIN     = 2'd3
    } tile_code_e;

    localparam logic [1:0] FS_DARK  = 2'd0;
    localparam logic [1:0] FS_MID   = 2'd1;
    localparam logic [1:0] FS_LIGHT = 2'd2;

    // Coin art is colour-keyed: the magenta key shows the sky behind the coin.
    function automatic rgb_t coin_rgb(input rgb_t raw, input rgb_t bg);
        return (raw == TRANSP_RGB) ? bg : raw;
    endfunction

endpackage

// File: rtl/sprite_fetch_ctrl_coin_anim_fsm.sv
// Coin shimmer sequencer: steps DARK->MID_UP->LIGHT->MID_DN every FRAMES_STEP frame ticks
// and publishes a frame-stable ROM select that only changes at start of frame.
module coin_anim_fsm
    import sprite_pkg::*;
#(
    parameter int FRAMES_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       sof,
    output logic [1:0] frame_sel
);

    localparam int STEP_W = (FRAMES_STEP > 1) ? $clog2(FRAMES_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_STEP - 1);

    localparam logic [1:0] ST_DARK   = 2'd0;
    localparam logic [1:0] ST_MID_UP = 2'd1;
    localparam logic [1:0] ST_LIGHT  = 2'd2;
    localparam logic [1:0] ST_MID_DN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        anim_sel;
    logic [STEP_W-1:0] step_q, step_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (frame_tick) begin
            if (step_q == STEP_LAST) begin
                step_d = '0;
                case (state_q)
                    ST_DARK:   state_d = ST_MID_UP;
                    ST_MID_UP: state_d = ST_LIGHT;
                    ST_LIGHT:  state_d = ST_MID_DN;
                    default:   state_d = ST_DARK;
                endcase
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end

        case (state_q)
            ST_DARK:  anim_sel = FS_DARK;
            ST_LIGHT: anim_sel = FS_LIGHT;
            default:  anim_sel = FS_MID;
        endcase

        // The sof pixel already sees the new select so the whole frame uses one value.
        sel_d = sof ? anim_sel : sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DARK;
            step_q  <= '0;
            sel_q   <= FS_DARK;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
        end
    end

    assign frame_sel = sel_d;

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Raster-to-tile address generator and ROM output mux for the tile/coin renderer.
// Pixel in -> ROM address (stage 0) -> ROM data (stage 1) -> registered RGB (stage 2).
module sprite_fetch_ctrl
    import sprite_pkg::*;
#(
    parameter int          FRAMES_STEP = 8,
    parameter logic [11:0] BG_RGB      = BG_RGB_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        sol,
    input  logic        sof,
    input  logic        frame_tick,
    output logic [5:0]  tile_col,
    output logic [4:0]  tile_row,
    input  logic [1:0]  tile_code,
    output logic [9:0]  rom_addr,
    input  logic [11:0] tile_pix,
    input  logic [11:0] plat_pix,
    input  logic [35:0] coin_pix,
    output logic [11:0] rgb_out,
    output logic        rgb_valid
);

    localparam logic [4:0] PX_LAST  = 5'(TILE_W - 1);
    localparam logic [4:0] COIN_LO  = 5'(COIN_OFF);
    localparam logic [4:0] COIN_HI  = 5'(COIN_OFF + COIN_W - 1);
    localparam logic [9:0] ROW_STEP = 10'(TILE_W);

    logic        line_start, frame_start;
    logic [4:0]  px_q, px_d, py_q, py_d, cur_px, cur_py;
    logic [5:0]  col_q, col_d, cur_col;
    logic [4:0]  row_q, row_d, cur_row;
    logic [9:0]  rb_q, rb_d, cur_rb;

    tile_code_e  code_in, code_q;
    logic        in_coin, in_coin_q;
    logic [3:0]  coin_dx, coin_dy;
    logic [9:0]  addr_d, rom_addr_q;
    logic [1:0]  frame_sel, frame_q;
    logic        valid_q;
    rgb_t        coin_raw, pix_d, rgb_q;
    logic        rgb_valid_q;

    coin_anim_fsm #(
        .FRAMES_STEP (FRAMES_STEP)
    ) u_anim (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .sof        (frame_start),
        .frame_sel  (frame_sel)
    );

    // px/col hold the position of the next pixel; py/row/row_base hold the current line.
    always_comb begin
        line_start  = pix_valid & sol;
        frame_start = line_start & sof;

        cur_px  = line_start ? '0 : px_q;
        cur_col = line_start ? '0 : col_q;
        cur_py  = py_q;
        cur_row = row_q;
        cur_rb  = rb_q;
        if (frame_start) begin
            cur_py  = '0;
            cur_row = '0;
            cur_rb  = '0;
        end else if (line_start) begin
            if (py_q == PX_LAST) begin
                cur_py  = '0;
                cur_row = row_q + 5'd1;
                cur_rb  = '0;
            end else begin
                cur_py  = py_q + 5'd1;
                cur_rb  = rb_q + ROW_STEP;
            end
        end

        px_d  = px_q;
        col_d = col_q;
        py_d  = py_q;
        row_d = row_q;
        rb_d  = rb_q;
        if (pix_valid) begin
            py_d  = cur_py;
            row_d = cur_row;
            rb_d  = cur_rb;
            if (cur_px == PX_LAST) begin
                px_d  = '0;
                col_d = cur_col + 6'd1;
            end else begin
                px_d  = cur_px + 5'd1;
                col_d = cur_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q  <= '0;
            py_q  <= '0;
            col_q <= '0;
            row_q <= '0;
            rb_q  <= '0;
        end else begin
            px_q  <= px_d;
            py_q  <= py_d;
            col_q <= col_d;
            row_q <= row_d;
            rb_q  <= rb_d;
        end
    end

    assign tile_col = cur_col;
    assign tile_row = cur_row;

    // Coin art is 16x16 inside the 24x24 cell, so its address is a 4+4 bit concatenation.
    always_comb begin
        code_in = tile_code_e'(tile_code);
        in_coin = (cur_px >= COIN_LO) && (cur_px <= COIN_HI) &&
                  (cur_py >= COIN_LO) && (cur_py <= COIN_HI);
        coin_dx = 4'(cur_px - COIN_LO);
        coin_dy = 4'(cur_py - COIN_LO);
        case (code_in)
            TC_GROUND, TC_PLATFORM: addr_d = cur_rb + {5'd0, cur_px};
            TC_COIN:                addr_d = in_coin ? {2'b00, coin_dy, coin_dx} : '0;
            default:                addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            code_q     <= TC_EMPTY;
            in_coin_q  <= 1'b0;
            frame_q    <= FS_DARK;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= pix_valid;
            if (pix_valid) begin
                rom_addr_q <= addr_d;
                code_q     <= code_in;
                in_coin_q  <= in_coin;
                frame_q    <= frame_sel;
            end
        end
    end

    assign rom_addr = rom_addr_q;

    always_comb begin
        case (frame_q)
            FS_MID:   coin_raw = coin_pix[23:12];
            FS_LIGHT: coin_raw = coin_pix[35:24];
            default:  coin_raw = coin_pix[11:0];
        endcase
        case (code_q)
            TC_GROUND:   pix_d = tile_pix;
            TC_PLATFORM: pix_d = plat_pix;
            TC_COIN:     pix_d = in_coin_q ? coin_rgb(coin_raw, BG_RGB) : BG_RGB;
            default:     pix_d = BG_RGB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q       <= BG_RGB;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_valid_q <= valid_q;
            if (valid_q) begin
                rgb_q <= pix_d;
            end
        end
    end

    assign rgb_out   = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule
